output_backprop_seq: RTL and testbench
======================================

Name: output_backprop_seq

Overview:
- Parametrised output-layer weight-update engine for the training datapath; next generation of the single-weight output backprop unit.
- On a start pulse it captures target, network output, N hidden activations and N current weights.
- Computes one shared error, then updates one weight per cycle through a saturating datapath.
- Raises a done pulse; the state machine consumes the updated weight vector at that point.

Parameters:
- N_HIDDEN, 4, number of hidden activations / output weights updated per pass
- W_WIDTH, 8, weight width, signed two's complement
- H_WIDTH, 10, hidden activation width, unsigned
- Y_WIDTH, 23, network output (final) width, unsigned
- T_WIDTH, 4, target width, unsigned
- LR_SHIFT, 2, learning rate as arithmetic right shift of gradient
- CLIP_MAX, 16, max |step| per weight; used only with GRAD_CLIP_EN

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous active-high reset
- start_i  in  1  begin a backward pass (b_pass from sm); sampled in IDLE only
- target_i  in  T_WIDTH  expected output
- final_i  in  Y_WIDTH  network output
- hidden_i  in  N_HIDDEN*H_WIDTH  activations; slice k = hidden k
- w_i  in  N_HIDDEN*W_WIDTH  current weights; slice k = weight k
- zero_weight_reset_i  in  1  synchronous clear of stored weights
- busy_o  out  1  high from the cycle after start until done
- w_o  out  N_HIDDEN*W_WIDTH  updated weight vector (registered)
- b_end_o  out  1  one-cycle pulse: update pass complete, w_o valid

Behaviour:
- Reset (rst_i=1, async): state IDLE, w_o=0, busy_o=0, b_end_o=0, index=0, all captures 0.
- FSM states: IDLE -> ERR -> UPD -> DONE -> IDLE.
- IDLE: when start_i=1, capture target_i, final_i, hidden_i, w_i; go to ERR. Inputs may change afterwards.
- ERR (1 cycle): e = final - target, signed, Y_WIDTH+1 bits, registered; index=0.
- UPD (N_HIDDEN cycles): for index k:
  - p = e * h_k, signed, Y_WIDTH+H_WIDTH+2 bits.
  - step = p >>> LR_SHIFT, arithmetic shift, rounds toward -inf.
  - w_new = w_k - step, computed at full width, then saturated to [-2^(W_WIDTH-1), 2^(W_WIDTH-1)-1].
  - Write w_new into slice k of the w_o register; increment index.
  - Leave UPD after k = N_HIDDEN-1.
- DONE (1 cycle): b_end_o=1, busy_o=0; return to IDLE.
- Latency: start in cycle 0; b_end_o high in cycle N_HIDDEN+2.
- w_o holds its value until the next pass or a clear.
- Slices not yet updated in a pass hold the captured w_i value, so the whole vector is loaded at start.
- start_i while not IDLE: ignored, no queuing.
- start_i in the DONE cycle: ignored; a new start is accepted the cycle after DONE.
- zero_weight_reset_i=1 on a clock edge: w_o=0, FSM to IDLE, no b_end_o; it overrides start_i in the same cycle.
- e=0 or h_k=0: step=0, weight passes through unchanged.
- rst_i asserted mid-pass: immediate return to reset values, no done pulse.

Optional Feature:
- Macro: GRAD_CLIP_EN.
- Defined: step is clamped to [-CLIP_MAX, CLIP_MAX] before the subtraction; saturation still applies afterwards.
- Undefined: no clamp; only output saturation applies. CLIP_MAX is unused.

Decomposition:
- Package output_bp_pkg: FSM state enum (IDLE, ERR, UPD, DONE); helper functions for signed W_WIDTH min/max saturation limits.
- Sub-module bp_sat_update: combinational multiply, shift, optional clip, subtract and saturate for one weight; instantiated once and time-multiplexed by index.

Test Plan (N_HIDDEN=4, W_WIDTH=8, LR_SHIFT=2):
- Basic update: target=3, final=5, all h=4, all w=10 -> e=2, step=2; b_end_o at cycle 6; w_o = 8,8,8,8.
- Positive saturation: target=15, final=0, h0=1023, w0=100 -> step=-3837, w0 -> 127; other slices with h=0 keep their captured w.
- Negative saturation: target=0, final=1000, h0=1000, w0=0 -> step=250000, w0 -> -128.
- Ignored start: start_i pulsed in cycles 2 and 4 of a pass -> single b_end_o at cycle 6, result identical to a single start.
- Clear and reset: zero_weight_reset_i during UPD -> w_o=0, no b_end_o, busy_o low next cycle; rst_i mid-pass -> all outputs 0 immediately.
- GRAD_CLIP_EN defined: target=0, final=100, h0=100, w0=50 -> raw step 2500 clamped to 16; w0=34.

Source files
------------

// File: rtl/output_bp_pkg.sv
// ----------------------------------------------------------------------------
// output_bp_pkg
// Shared types and helpers for the output-layer weight-update engine.
//   state_e  : FSM states of output_backprop_seq (IDLE, ERR, UPD, DONE)
//   sat_max  : largest value of a signed two's complement number of width w
//   sat_min  : smallest value of a signed two's complement number of width w
// ----------------------------------------------------------------------------
package output_bp_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ERR  = 2'd1,
        UPD  = 2'd2,
        DONE = 2'd3
    } state_e;

    function automatic longint sat_max(input int w);
        return (longint'(1) <<< (w - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int w);
        return -(longint'(1) <<< (w - 1));
    endfunction

endpackage

// File: rtl/bp_sat_update.sv
// ----------------------------------------------------------------------------
// bp_sat_update
// Combinational update of one output weight:
//   p     = e * h                 (signed, Y_WIDTH+H_WIDTH+2 bits)
//   step  = p >>> LR_SHIFT        (rounds toward -inf)
//   step  clamped to [-CLIP_MAX, CLIP_MAX] when GRAD_CLIP_EN is defined
//   w_new = sat(w_cur - step)     (saturated to the signed W_WIDTH range)
// Optional feature macro: GRAD_CLIP_EN (gradient step clamp).
// Ports:
//   e      in  Y_WIDTH+1  shared output error (signed)
//   h      in  H_WIDTH    hidden activation (unsigned)
//   w_cur  in  W_WIDTH    current weight (signed)
//   w_new  out W_WIDTH    updated, saturated weight (signed)
// ----------------------------------------------------------------------------
module bp_sat_update
    import output_bp_pkg::*;
#(
    parameter int W_WIDTH  = 8,
    parameter int H_WIDTH  = 10,
    parameter int Y_WIDTH  = 23,
    parameter int LR_SHIFT = 2,
    parameter int CLIP_MAX = 16
) (
    input  logic signed [Y_WIDTH:0]   e,
    input  logic        [H_WIDTH-1:0] h,
    input  logic signed [W_WIDTH-1:0] w_cur,
    output logic signed [W_WIDTH-1:0] w_new
);

    localparam int P_W = Y_WIDTH + H_WIDTH + 2;
    localparam int D_W = P_W + 1;   // one extra bit so w_cur - step cannot wrap

`ifdef GRAD_CLIP_EN
    localparam bit CLIP_ON = 1'b1;
`else
    localparam bit CLIP_ON = 1'b0;
`endif

    localparam logic signed [P_W-1:0] CLIP_HI = P_W'(CLIP_MAX);
    localparam logic signed [P_W-1:0] CLIP_LO = -P_W'(CLIP_MAX);
    localparam logic signed [D_W-1:0] W_HI    = D_W'(sat_max(W_WIDTH));
    localparam logic signed [D_W-1:0] W_LO    = D_W'(sat_min(W_WIDTH));

    logic signed [P_W-1:0] p;
    logic signed [P_W-1:0] step;
    logic signed [P_W-1:0] step_lim;
    logic signed [D_W-1:0] w_diff;

    always_comb begin
        // Activation is unsigned: prepend a zero before the signed multiply.
        p        = P_W'(e) * P_W'($signed({1'b0, h}));
        step     = p >>> LR_SHIFT;
        step_lim = step;
        if (CLIP_ON) begin
            if (step > CLIP_HI)      step_lim = CLIP_HI;
            else if (step < CLIP_LO) step_lim = CLIP_LO;
        end
        w_diff = D_W'(w_cur) - D_W'(step_lim);
        if (w_diff > W_HI)      w_new = W_HI[W_WIDTH-1:0];
        else if (w_diff < W_LO) w_new = W_LO[W_WIDTH-1:0];
        else                    w_new = w_diff[W_WIDTH-1:0];
    end

endmodule

// File: rtl/output_backprop_seq.sv
// ----------------------------------------------------------------------------
// output_backprop_seq
// Output-layer weight-update engine. A start pulse captures target, network
// output, N_HIDDEN activations and N_HIDDEN weights; one shared error is
// computed, then one weight per cycle is updated through bp_sat_update.
// Optional feature macro: GRAD_CLIP_EN (clamps each step to +/-CLIP_MAX).
//
// Handshake: start_i is a request sampled only in IDLE (ignored elsewhere,
// never queued); busy_o is high in the ERR/UPD cycles; b_end_o is a one-cycle
// completion pulse in DONE, during which w_o already holds the full result.
// zero_weight_reset_i clears w_o and aborts any pass without a b_end_o.
//
// Ports:
//   clk_i, rst_i            clock, asynchronous active-high reset
//   start_i                 begin a backward pass
//   target_i, final_i       expected and actual network output (unsigned)
//   hidden_i, w_i           packed activations / weights, slice k = entry k
//   zero_weight_reset_i     synchronous clear of stored weights
//   busy_o, b_end_o, w_o    status, done pulse, registered weight vector
//   state_o                 current FSM state (debug)
// ----------------------------------------------------------------------------
module output_backprop_seq
    import output_bp_pkg::*;
#(
    parameter int N_HIDDEN = 4,
    parameter int W_WIDTH  = 8,
    parameter int H_WIDTH  = 10,
    parameter int Y_WIDTH  = 23,
    parameter int T_WIDTH  = 4,
    parameter int LR_SHIFT = 2,
    parameter int CLIP_MAX = 16
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start_i,
    input  logic [T_WIDTH-1:0]           target_i,
    input  logic [Y_WIDTH-1:0]           final_i,
    input  logic [N_HIDDEN*H_WIDTH-1:0]  hidden_i,
    input  logic [N_HIDDEN*W_WIDTH-1:0]  w_i,
    input  logic                         zero_weight_reset_i,
    output logic                         busy_o,
    output logic [N_HIDDEN*W_WIDTH-1:0]  w_o,
    output logic                         b_end_o,
    output state_e                       state_o
);

    localparam int IDX_W = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_HIDDEN - 1);

    state_e                        state;
    state_e                        state_nx;
    logic [T_WIDTH-1:0]            t_q;
    logic [Y_WIDTH-1:0]            y_q;
    logic [N_HIDDEN*H_WIDTH-1:0]   h_q;
    logic signed [Y_WIDTH:0]       e_q;
    logic [IDX_W-1:0]              idx;
    logic [N_HIDDEN*W_WIDTH-1:0]   w_q;
    logic [H_WIDTH-1:0]            h_sel;
    logic signed [W_WIDTH-1:0]     w_sel;
    logic signed [W_WIDTH-1:0]     w_new;

    // One datapath, time-multiplexed by idx across the UPD cycles.
    assign h_sel = h_q[idx*H_WIDTH +: H_WIDTH];
    assign w_sel = w_q[idx*W_WIDTH +: W_WIDTH];

    bp_sat_update #(
        .W_WIDTH  (W_WIDTH),
        .H_WIDTH  (H_WIDTH),
        .Y_WIDTH  (Y_WIDTH),
        .LR_SHIFT (LR_SHIFT),
        .CLIP_MAX (CLIP_MAX)
    ) u_upd (
        .e     (e_q),
        .h     (h_sel),
        .w_cur (w_sel),
        .w_new (w_new)
    );

    always_comb begin
        state_nx = state;
        busy_o   = 1'b0;
        b_end_o  = 1'b0;
        case (state)
            IDLE: if (start_i) state_nx = ERR;
            ERR: begin
                busy_o   = 1'b1;
                state_nx = UPD;
            end
            UPD: begin
                busy_o = 1'b1;
                if (idx == IDX_LAST) state_nx = DONE;
            end
            DONE: begin
                b_end_o  = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // The clear wins over everything, including a start in IDLE.
        if (zero_weight_reset_i) state_nx = IDLE;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= IDLE;
            t_q   <= '0;
            y_q   <= '0;
            h_q   <= '0;
            e_q   <= '0;
            idx   <= '0;
            w_q   <= '0;
        end else begin
            state <= state_nx;
            if (zero_weight_reset_i) begin
                w_q <= '0;
                idx <= '0;
            end else begin
                case (state)
                    IDLE: if (start_i) begin
                        t_q <= target_i;
                        y_q <= final_i;
                        h_q <= hidden_i;
                        // Whole vector loaded so untouched slices hold w_i.
                        w_q <= w_i;
                    end
                    ERR: begin
                        e_q <= $signed({1'b0, y_q})
                             - $signed({{(Y_WIDTH - T_WIDTH + 1){1'b0}}, t_q});
                        idx <= '0;
                    end
                    UPD: begin
                        w_q[idx*W_WIDTH +: W_WIDTH] <= w_new;
                        idx <= idx + IDX_W'(1);
                    end
                    default: ;
                endcase
            end
        end
    end

    assign w_o     = w_q;
    assign state_o = state;

endmodule

// File: tb/tb_output_backprop_seq.sv
module tb_output_backprop_seq;
    import output_bp_pkg::*;

    localparam int N    = 4;
    localparam int W_W  = 8;
    localparam int H_W  = 10;
    localparam int Y_W  = 23;
    localparam int T_W  = 4;
    localparam int LR   = 2;
    localparam int CLIP = 16;
    localparam int LAT  = N + 2;

    logic               clk;
    logic               rst;
    logic               start;
    logic [T_W-1:0]     target;
    logic [Y_W-1:0]     final_v;
    logic [N*H_W-1:0]   hidden;
    logic [N*W_W-1:0]   w_in;
    logic               zero_rst;
    logic               busy;
    logic [N*W_W-1:0]   w_out;
    logic               b_end;
    state_e             state_dbg;

    int errors = 0;
    int checks = 0;

    output_backprop_seq #(
        .N_HIDDEN(N), .W_WIDTH(W_W), .H_WIDTH(H_W), .Y_WIDTH(Y_W),
        .T_WIDTH(T_W), .LR_SHIFT(LR), .CLIP_MAX(CLIP)
    ) dut (
        .clk_i               (clk),
        .rst_i               (rst),
        .start_i             (start),
        .target_i            (target),
        .final_i             (final_v),
        .hidden_i            (hidden),
        .w_i                 (w_in),
        .zero_weight_reset_i (zero_rst),
        .busy_o              (busy),
        .w_o                 (w_out),
        .b_end_o             (b_end),
        .state_o             (state_dbg)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- reference model ----------------
    // Arithmetic view: error, product, floor-divide by 2^LR, optional clamp,
    // subtract, clamp into the signed weight range.
    function automatic logic [N*W_W-1:0] model(input logic [T_W-1:0] t,
                                               input logic [Y_W-1:0] y,
                                               input logic [N*H_W-1:0] h,
                                               input logic [N*W_W-1:0] w);
        logic [N*W_W-1:0] res;
        longint e, p, step, wk, wn, d, hi, lo;
        logic [W_W-1:0] ws;
        d  = longint'(1) << LR;
        hi = (longint'(1) << (W_W - 1)) - 1;
        lo = -(longint'(1) << (W_W - 1));
        e  = longint'(y) - longint'(t);
        res = '0;
        for (int k = 0; k < N; k++) begin
            ws = w[k*W_W +: W_W];
            wk = longint'($signed(ws));
            p  = e * longint'(h[k*H_W +: H_W]);
            if (p >= 0) step = p / d;
            else        step = -((-p + d - 1) / d);
`ifdef GRAD_CLIP_EN
            if (step > CLIP)  step = CLIP;
            if (step < -CLIP) step = -CLIP;
`endif
            wn = wk - step;
            if (wn > hi) wn = hi;
            if (wn < lo) wn = lo;
            res[k*W_W +: W_W] = W_W'(wn);
        end
        return res;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic randomize_inputs();
        target  = T_W'($urandom);
        final_v = Y_W'($urandom);
        hidden  = (N*H_W)'({$urandom, $urandom});
        w_in    = (N*W_W)'({$urandom, $urandom});
    endtask

    task automatic do_reset();
        rst = 1'b1; start = 1'b0; zero_rst = 1'b0;
        randomize_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Full pass: start in cycle 0, checks busy/b_end per cycle, w_o capture in
    // cycle 1, b_end latency and final vector against the scoreboard queue.
    task automatic run_pass(input logic [T_W-1:0] t, input logic [Y_W-1:0] y,
                            input logic [N*H_W-1:0] h, input logic [N*W_W-1:0] w,
                            input bit extra_starts, input string name);
        logic [N*W_W-1:0] exp_q[$];
        logic [N*W_W-1:0] exp_w;
        int cnt;
        bit seen;
        exp_q.push_back(model(t, y, h, w));
        @(negedge clk);
        target = t; final_v = y; hidden = h; w_in = w; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        randomize_inputs();
        cnt = 1; seen = 1'b0;
        while (!seen && cnt < 20) begin
            @(negedge clk);
            if (cnt == 1) begin
                checks++;
                if (w_out !== w) begin
                    errors++;
                    $display("FAIL %s capture: w_o=%h expected %h", name, w_out, w);
                end
            end
            if (b_end === 1'b1) begin
                seen = 1'b1;
                exp_w = exp_q.pop_front();
                checks++;
                if (cnt != LAT) begin
                    errors++;
                    $display("FAIL %s latency: b_end at cycle %0d expected %0d", name, cnt, LAT);
                end
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL %s busy_in_done: busy=%b expected 0", name, busy);
                end
                checks++;
                if (w_out !== exp_w) begin
                    errors++;
                    $display("FAIL %s result: w_o=%h expected %h", name, w_out, exp_w);
                end
            end else begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL %s busy: cycle %0d busy=%b expected 1", name, cnt, busy);
                end
                start = extra_starts && (cnt == 2 || cnt == 4);
                @(posedge clk);
                #1 cnt++;
            end
        end
        start = 1'b0;
        if (!seen) begin
            errors++; checks++;
            $display("FAIL %s timeout: no b_end within %0d cycles", name, cnt);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        do_reset();
        @(negedge clk);
        checks++;
        if (w_out !== '0)   begin errors++; $display("FAIL reset_w: w_o=%h expected 0", w_out); end
        checks++;
        if (busy !== 1'b0)  begin errors++; $display("FAIL reset_busy: busy=%b expected 0", busy); end
        checks++;
        if (b_end !== 1'b0) begin errors++; $display("FAIL reset_b_end: b_end=%b expected 0", b_end); end
    endtask

    task automatic test_basic();
        run_pass(4'd3, 23'd5, {4{10'd4}}, {4{8'd10}}, 1'b0, "basic");
        checks++;
        if (w_out !== {4{8'd8}}) begin
            errors++; $display("FAIL basic_const: w_o=%h expected %h", w_out, {4{8'd8}});
        end
        // Zero error: weights pass through unchanged.
        run_pass(4'd9, 23'd9, {10'd1023, 10'd17, 10'd500, 10'd3}, 32'h80_7F_C3_11, 1'b0, "zero_err");
    endtask

    task automatic test_saturation();
        run_pass(4'd15, 23'd0, {10'd0, 10'd0, 10'd0, 10'd1023}, {8'd5, 8'hFB, 8'd77, 8'd100}, 1'b0, "pos_sat");
        run_pass(4'd0, 23'd1000, {10'd0, 10'd0, 10'd0, 10'd1000}, {8'd1, 8'd2, 8'd3, 8'd0}, 1'b0, "neg_sat");
        run_pass(4'd0, 23'd100, {10'd0, 10'd0, 10'd0, 10'd100}, {8'd9, 8'd9, 8'd9, 8'd50}, 1'b0, "clip");
    endtask

    task automatic test_random();
        for (int i = 0; i < 20; i++) begin
            logic [T_W-1:0] t;
            logic [Y_W-1:0] y;
            t = T_W'($urandom);
            y = (i % 2 == 0) ? Y_W'($urandom_range(0, 40)) : Y_W'($urandom);
            run_pass(t, y, (N*H_W)'({$urandom, $urandom}), (N*W_W)'($urandom), 1'b0, "random");
        end
    endtask

    task automatic test_ignored_start();
        int bad;
        run_pass(4'd3, 23'd5, {10'd4, 10'd8, 10'd1, 10'd4}, {8'd10, 8'hF0, 8'd10, 8'd10}, 1'b1, "ignored_start");
        bad = 0;
        repeat (5) begin
            @(negedge clk);
            if (b_end !== 1'b0 || busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL ignored_start_extra: %0d active cycles expected 0", bad); end
    endtask

    task automatic test_back_to_back_and_done_start();
        int bad;
        run_pass(4'd1, 23'd7, (N*H_W)'({$urandom, $urandom}), (N*W_W)'($urandom), 1'b0, "b2b_a");
        run_pass(4'd2, 23'd3, (N*H_W)'({$urandom, $urandom}), (N*W_W)'($urandom), 1'b0, "b2b_b");
        // Now in the DONE cycle: a start here must be ignored.
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL done_start: busy in %0d cycles expected 0", bad); end
    endtask

    task automatic test_clear();
        int bad;
        @(negedge clk);
        target = 4'd3; final_v = 23'd5; hidden = {4{10'd4}}; w_in = {4{8'd10}}; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (3) @(negedge clk);     // cycle 3, inside UPD
        zero_rst = 1'b1;
        @(posedge clk);
        #1 zero_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (w_out !== '0)  begin errors++; $display("FAIL clear_w: w_o=%h expected 0", w_out); end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL clear_busy: busy=%b expected 0", busy); end
        bad = 0;
        repeat (8) begin
            if (b_end !== 1'b0) bad++;
            @(negedge clk);
        end
        checks++;
        if (bad != 0) begin errors++; $display("FAIL clear_no_done: b_end seen %0d times expected 0", bad); end
        // Clear together with start in IDLE: clear wins.
        w_in = {4{8'd33}}; start = 1'b1; zero_rst = 1'b1;
        @(posedge clk);
        #1 start = 1'b0; zero_rst = 1'b0;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || w_out !== '0) begin
            errors++; $display("FAIL clear_vs_start: busy=%b w_o=%h expected 0/0", busy, w_out);
        end
    endtask

    task automatic test_reset_mid_pass();
        @(negedge clk);
        target = 4'd0; final_v = 23'd9; hidden = {4{10'd2}}; w_in = {4{8'd40}}; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (4) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        checks++;
        if (w_out !== '0 || busy !== 1'b0 || b_end !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid: w_o=%h busy=%b b_end=%b expected 0/0/0", w_out, busy, b_end);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if (b_end !== 1'b0 || busy !== 1'b0) begin
            errors++; $display("FAIL reset_mid_after: busy=%b b_end=%b expected 0/0", busy, b_end);
        end
    endtask

    // ---------------- sequence + report ----------------
    initial begin
        test_reset();
        test_basic();
        test_saturation();
        test_random();
        test_ignored_start();
        test_back_to_back_and_done_start();
        test_clear();
        test_reset_mid_pass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
        $fatal(1, "watchdog");
    end

endmodule
